debouncer_multi: RTL and testbench

DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_channel.sv | 61 ++++++
 rtl/debouncer_multi.sv | 73 +++++++
 tb/tb_debouncer_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel push-button debouncer.
package debounce_pkg;

  localparam int unsigned DEF_NUM_CH     = 2;
  localparam int unsigned DEF_TICK_DIV   = 1250000;
  localparam int unsigned DEF_STABLE_CNT = 4;
  localparam int unsigned DEF_ACTIVE_LOW = 0;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int unsigned clog2w(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: accepts a new level after STABLE_CNT consecutive
// differing samples taken on tick cycles, and emits registered edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic sample,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = clog2w(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any sample matching the current level restarts the run of differing samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick_en) begin
      if (sample == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = sample;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel push-button debouncer: input synchronizers, shared sample-tick
// generator and one debounce_channel per button.
module debouncer_multi
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
  parameter int unsigned ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pb_in,
  output logic [NUM_CH-1:0] pb_level,
  output logic [NUM_CH-1:0] pb_rise,
  output logic [NUM_CH-1:0] pb_fall,
  output logic              tick
);

  localparam int unsigned        TW        = clog2w(TICK_DIV);
  localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [NUM_CH-1:0]  NORM      = {NUM_CH{1'(ACTIVE_LOW)}};

  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] sample_c;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;

  // Two-flop synchronizer; reset value reads as "released" after normalization.
  always_comb begin
    sync1_d  = pb_in;
    sync2_d  = sync1_q;
    sample_c = sync2_q ^ NORM;
  end

  // tick_q is high exactly while the counter sits at its last value.
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    tick_d     = (tick_cnt_d == TICK_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= NORM;
      sync2_q    <= NORM;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar ch = 0; ch < int'(NUM_CH); ch++) begin : g_ch
    debounce_channel #(
      .STABLE_CNT(STABLE_CNT)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_en(tick_q),
      .sample (sample_c[ch]),
      .level  (pb_level[ch]),
      .rise   (pb_rise[ch]),
      .fall   (pb_fall[ch])
    );
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: an active-high and an active-low instance checked
// every cycle against a behavioural model, plus hand-computed spot values.
module tb_debouncer_multi;

  localparam int TD = 4;
  localparam int SC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pb_a, pb_b;
  logic [1:0] lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b;
  logic       tick_a, tick_b;

  int errors = 0;
  int checks = 0;
  int n_rise_a0 = 0, n_fall_a0 = 0, n_rise_b1 = 0;
  int s_r, s_f, s_rb;

  always #5 clk = ~clk;

  debouncer_multi #(.NUM_CH(2), .TICK_DIV(TD), .STABLE_CNT(SC), .ACTIVE_LOW(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .pb_in(pb_a),
    .pb_level(lvl_a), .pb_rise(rise_a), .pb_fall(fall_a), .tick(tick_a)
  );

  debouncer_multi #(.NUM_CH(2), .TICK_DIV(TD), .STABLE_CNT(SC), .ACTIVE_LOW(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pb_in(pb_b),
    .pb_level(lvl_b), .pb_rise(rise_b), .pb_fall(fall_b), .tick(tick_b)
  );

  // Behavioural model: index 0 = active-high instance, 1 = active-low instance.
  logic [1:0] al_mask [2] = '{2'b00, 2'b11};
  logic [1:0] md1 [2], md2 [2], mlvl [2], mrise [2], mfall [2];
  int         mcnt [2][2];
  int         medges;
  logic       mtick;
  logic       m_en;
  logic [1:0] m_smp;

  task automatic m_reset();
    medges = 0;
    mtick  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      md1[d] = al_mask[d];
      md2[d] = al_mask[d];
      mlvl[d] = 2'b00; mrise[d] = 2'b00; mfall[d] = 2'b00;
      for (int c = 0; c < 2; c++) mcnt[d][c] = 0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        // tick seen during the finishing cycle enables this edge's sample
        m_en = mtick;
        for (int d = 0; d < 2; d++) begin
          m_smp  = md2[d] ^ al_mask[d];
          md2[d] = md1[d];
          md1[d] = (d == 0) ? pb_a : pb_b;
          mrise[d] = 2'b00;
          mfall[d] = 2'b00;
          for (int c = 0; c < 2; c++) begin
            if (m_en) begin
              if (m_smp[c] != mlvl[d][c]) begin
                mcnt[d][c]++;
                if (mcnt[d][c] == SC) begin
                  mcnt[d][c] = 0;
                  mlvl[d][c] = m_smp[c];
                  if (m_smp[c]) mrise[d][c] = 1'b1;
                  else          mfall[d][c] = 1'b1;
                end
              end else begin
                mcnt[d][c] = 0;
              end
            end
          end
        end
        medges++;
        mtick = ((medges % TD) == TD - 1);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("model_tick_a", 32'(tick_a), 32'(mtick));
    chk("model_tick_b", 32'(tick_b), 32'(mtick));
    chk("model_level_a", 32'(lvl_a), 32'(mlvl[0]));
    chk("model_rise_a", 32'(rise_a), 32'(mrise[0]));
    chk("model_fall_a", 32'(fall_a), 32'(mfall[0]));
    chk("model_level_b", 32'(lvl_b), 32'(mlvl[1]));
    chk("model_rise_b", 32'(rise_b), 32'(mrise[1]));
    chk("model_fall_b", 32'(fall_b), 32'(mfall[1]));
    n_rise_a0 += int'(rise_a[0]);
    n_fall_a0 += int'(fall_a[0]);
    n_rise_b1 += int'(rise_b[1]);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_all();
    end
  endtask

  // Returns at the falling edge of a cycle where tick is high.
  task automatic wait_tick();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      cmp_all();
      if (tick_a) got = 1'b1;
    end
    chk("tick_timeout", 32'(got), 32'd1);
  endtask

  // Present a value for exactly n enabled samples; call tick-aligned.
  task automatic hold(input logic [1:0] va, input logic [1:0] vb, input int n);
    pb_a = va;
    pb_b = vb;
    repeat (n) wait_tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    pb_a  = 2'b11;
    pb_b  = 2'b11;
    cyc(3);
    chk("rst_level_a", 32'(lvl_a), 32'd0);
    chk("rst_pulses_a", 32'({rise_a, fall_a}), 32'd0);
    chk("rst_tick", 32'(tick_a), 32'd0);
    chk("rst_level_b", 32'(lvl_b), 32'd0);

    // clean press on channel 0 held from reset release
    rst_n = 1'b1;
    pb_a  = 2'b01;
    cyc(2); chk("tick_before_first", 32'(tick_a), 32'd0);
    cyc(1); chk("tick_first", 32'(tick_a), 32'd1);
    cyc(1); chk("tick_one_cycle", 32'(tick_a), 32'd0);
    cyc(7); chk("press_not_yet", 32'(lvl_a), 32'd0);
            chk("tick_second", 32'(tick_a), 32'd1);
    cyc(1); chk("press_level", 32'(lvl_a), 32'b01);
            chk("press_rise", 32'(rise_a), 32'b01);
    cyc(1); chk("press_rise_end", 32'(rise_a), 32'd0);
            chk("press_level_hold", 32'(lvl_a), 32'b01);

    // release
    wait_tick();
    s_r = n_rise_a0; s_f = n_fall_a0;
    hold(2'b00, 2'b11, 3);
    cyc(1); chk("release_level", 32'(lvl_a), 32'd0);
            chk("release_fall", 32'(fall_a), 32'b01);
    cyc(1); chk("release_fall_end", 32'(fall_a), 32'd0);
    chk("release_no_rise", 32'(n_rise_a0 - s_r), 32'd0);
    chk("release_one_fall", 32'(n_fall_a0 - s_f), 32'd1);

    // bounce on A channel 0, active-low press on B channel 1
    wait_tick();
    s_r = n_rise_a0; s_rb = n_rise_b1;
    hold(2'b01, 2'b01, 2);
    hold(2'b00, 2'b01, 1);
    hold(2'b01, 2'b01, 2);
    cyc(1); chk("bounce_held_off", 32'(lvl_a), 32'd0);
            chk("active_low_level", 32'(lvl_b), 32'b10);
    wait_tick(); chk("bounce_still_off", 32'(lvl_a), 32'd0);
    cyc(1); chk("bounce_level", 32'(lvl_a), 32'b01);
            chk("bounce_rise", 32'(rise_a), 32'b01);
    chk("bounce_one_rise", 32'(n_rise_a0 - s_r), 32'd1);
    chk("active_low_one_rise", 32'(n_rise_b1 - s_rb), 32'd1);

    // simultaneous opposite changes on both channels
    wait_tick();
    hold(2'b10, 2'b11, 3);
    cyc(1); chk("simul_level", 32'(lvl_a), 32'b10);
            chk("simul_rise", 32'(rise_a), 32'b10);
            chk("simul_fall", 32'(fall_a), 32'b01);
            chk("simul_fall_b", 32'(fall_b), 32'b10);

    // reset after two differing samples, buttons held through it
    wait_tick();
    hold(2'b01, 2'b01, 2);
    cyc(1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_level_a", 32'(lvl_a), 32'd0);
       chk("midrst_level_b", 32'(lvl_b), 32'd0);
       chk("midrst_tick", 32'(tick_a), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(11); chk("midrst_not_yet", 32'(lvl_a), 32'd0);
    cyc(1);  chk("midrst_level", 32'(lvl_a), 32'b01);
             chk("midrst_rise", 32'(rise_a), 32'b01);
             chk("midrst_level_b_press", 32'(lvl_b), 32'b10);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
